// File: rtl/av2_txfm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : av2_txfm_pkg
//  Brief    : Shared constants, mode type and round/clamp helper for the
//             4-point inverse transform stream.
//  Revision : 1.0 - initial release
// ============================================================================
package av2_txfm_pkg;

  // DCT4 butterfly multipliers
  localparam int DCT_C64 = 64;
  localparam int DCT_C83 = 83;
  localparam int DCT_C36 = 36;

  // Transform mode, latched per block
  typedef enum logic {
    TXM_DCT4 = 1'b0,
    TXM_IDN  = 1'b1
  } txm_e;

  // Round-half-up, arithmetic (floor) shift, then saturate to a signed out_w range.
  function automatic logic signed [31:0] round_clamp(
    input logic signed [31:0] y,
    input int                 shift,
    input int                 out_w
  );
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = (y + (32'sd1 <<< (shift - 1))) >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/av2_inv_dct4_core.sv
`default_nettype none
// ============================================================================
//  Module   : av2_inv_dct4_core
//  Brief    : Combinational 4-lane inverse DCT4 butterfly or identity scale.
//             Output lanes are full precision (before round/shift/clamp).
//  Revision : 1.0 - initial release
// ============================================================================
module av2_inv_dct4_core
  import av2_txfm_pkg::*;
#(
  parameter int COEF_W   = 16,
  parameter int YW       = COEF_W + 9,
  parameter int IDN_MULT = 128
) (
  input  txm_e                  i_mode,
  input  logic [4*COEF_W-1:0]   i_coef,
  output logic [4*YW-1:0]       o_y
);

  logic signed [YW-1:0] w_c [4];
  logic signed [YW-1:0] w_k64;
  logic signed [YW-1:0] w_k83;
  logic signed [YW-1:0] w_k36;
  logic signed [YW-1:0] w_kidn;
  logic signed [YW-1:0] w_e0;
  logic signed [YW-1:0] w_e1;
  logic signed [YW-1:0] w_o0;
  logic signed [YW-1:0] w_o1;

  assign w_k64  = YW'(DCT_C64);
  assign w_k83  = YW'(DCT_C83);
  assign w_k36  = YW'(DCT_C36);
  assign w_kidn = YW'(IDN_MULT);

  // Sign-extend every input lane to the working width
  for (genvar k = 0; k < 4; k++) begin : g_ext
    assign w_c[k] = YW'($signed(i_coef[k*COEF_W +: COEF_W]));
  end

  // Even/odd halves of the butterfly
  assign w_e0 = w_k64 * (w_c[0] + w_c[2]);
  assign w_e1 = w_k64 * (w_c[0] - w_c[2]);
  assign w_o0 = w_k83 * w_c[1] + w_k36 * w_c[3];
  assign w_o1 = w_k36 * w_c[1] - w_k83 * w_c[3];

  // Select butterfly recombination or per-lane identity scaling
  always_comb begin
    o_y = '0;
    if (i_mode == TXM_IDN) begin
      o_y = {w_c[3] * w_kidn, w_c[2] * w_kidn, w_c[1] * w_kidn, w_c[0] * w_kidn};
    end else begin
      o_y = {w_e0 - w_o0, w_e1 - w_o1, w_e1 + w_o1, w_e0 + w_o0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/av2_inv_txfm4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : av2_inv_txfm4_stream
//  Brief    : Streaming 1-D inverse transform, one row of 4 coefficients per
//             beat. Two-stage pipeline (butterfly, round/clamp) with full
//             valid/ready backpressure; blocks framed by start/done.
//  Revision : 1.0 - initial release
// ============================================================================
module av2_inv_txfm4_stream
  import av2_txfm_pkg::*;
#(
  parameter int COEF_W   = 16,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 7,
  parameter int IDN_MULT = 128,
  parameter int ROWS_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROWS_W-1:0]     tx_rows,
  input  logic                  tx_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*COEF_W-1:0]   in_coef,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*OUT_W-1:0]    out_res,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int YW = COEF_W + 9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           r_state;
  logic [ROWS_W-1:0]    r_rows;
  txm_e                 r_mode;
  logic [ROWS_W-1:0]    r_in_cnt;
  logic [ROWS_W-1:0]    r_out_cnt;
  logic                 r_s1_valid;
  logic [4*YW-1:0]      r_s1_y;
  logic                 r_s2_valid;
  logic [4*OUT_W-1:0]   r_out_res;
  logic                 r_done;

  logic                 w_advance;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_last_row;
  logic [4*YW-1:0]      w_y;
  logic [4*OUT_W-1:0]   w_res;

  // Whole pipeline moves only when the output register is free or draining
  assign w_advance  = !r_s2_valid || out_ready;
  assign w_in_ready = (r_state == ST_RUN) && (r_in_cnt != r_rows) && w_advance;
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_s2_valid && out_ready;
  assign w_last_row = (r_out_cnt == r_rows - 1'b1);

  av2_inv_dct4_core #(
    .COEF_W   (COEF_W),
    .YW       (YW),
    .IDN_MULT (IDN_MULT)
  ) u_core (
    .i_mode (r_mode),
    .i_coef (in_coef),
    .o_y    (w_y)
  );

  // Round, shift and saturate each stage-1 lane
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic signed [YW-1:0] w_ys;
    assign w_ys = r_s1_y[k*YW +: YW];
    assign w_res[k*OUT_W +: OUT_W] = OUT_W'(round_clamp(32'(w_ys), SHIFT, OUT_W));
  end

  // Block control: latch block parameters, count rows, finish on last output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rows    <= '0;
      r_mode    <= TXM_DCT4;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_rows    <= (tx_rows == '0) ? ROWS_W'(1) : tx_rows;
            r_mode    <= txm_e'(tx_mode);
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (w_in_fire) begin
            r_in_cnt <= r_in_cnt + 1'b1;
          end
          if (w_out_fire) begin
            if (w_last_row) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage data pipeline, frozen while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_s2_valid <= 1'b0;
      r_out_res  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_y <= w_y;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_res <= w_res;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_res   = r_out_res;
  assign out_last  = r_s2_valid && w_last_row;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;

endmodule
`default_nettype wire
